bf_wb_ctrl: RTL and testbench

- Write-back stage directly downstream of the butterfly output network.
- Captures the four routed lanes d0..d3 and pairs each with the bank address issued when the operands were read. The address is delayed by the butterfly pipeline latency.
- Drives the four bank write ports.
- Tracks per-stage progress through a small FSM and signals stage completion to the stage sequencer.

---
 rtl/bf_wb_ctrl_pkg.sv | 27 ++
 rtl/bf_wb_ctrl_delay_line.sv | 27 ++
 rtl/bf_wb_ctrl.sv | 138 +++++++++++++
 tb/tb_bf_wb_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_wb_ctrl_pkg.sv
// Shared types, default parameters and helpers for the butterfly write-back stage.
// The four output lanes are always written together as one group.
package bf_wb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } wb_state_t;

    localparam int NUM_LANES      = 4;
    localparam int DEF_DATA_WIDTH = 14;
    localparam int DEF_ADDR_WIDTH = 6;
    localparam int DEF_LAT        = 14;
    localparam int DEF_PER_STAGE  = 64;

    // Bits needed to hold values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < value) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/bf_wb_ctrl_delay_line.sv
// Fixed-depth shift register that carries issue metadata alongside the
// butterfly pipeline; async clear drops everything in flight.
module wb_delay_line #(
    parameter int width = 1,
    parameter int depth = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    logic [depth-1:0][width-1:0] sr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr <= '0;
        end else begin
            sr[0] <= din;
            for (int i = 1; i < depth; i++)
                sr[i] <= sr[i-1];
        end
    end

    assign dout = sr[depth-1];

endmodule

// File: rtl/bf_wb_ctrl.sv
// Write-back stage behind the butterfly output network: pairs routed lane data
// with the delayed read addresses, drives the bank write ports, tracks the stage.
module bf_wb_ctrl
    import bf_wb_ctrl_pkg::*;
#(
    parameter int data_width = DEF_DATA_WIDTH,
    parameter int addr_width = DEF_ADDR_WIDTH,
    parameter int LAT        = DEF_LAT,
    parameter int PER_STAGE  = DEF_PER_STAGE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  issue_valid,
    input  logic [addr_width-1:0] issue_addr_0,
    input  logic [addr_width-1:0] issue_addr_1,
    input  logic [addr_width-1:0] issue_addr_2,
    input  logic [addr_width-1:0] issue_addr_3,
    input  logic [data_width-1:0] d0,
    input  logic [data_width-1:0] d1,
    input  logic [data_width-1:0] d2,
    input  logic [data_width-1:0] d3,
    output logic                  wen_0,
    output logic                  wen_1,
    output logic                  wen_2,
    output logic                  wen_3,
    output logic [addr_width-1:0] waddr_0,
    output logic [addr_width-1:0] waddr_1,
    output logic [addr_width-1:0] waddr_2,
    output logic [addr_width-1:0] waddr_3,
    output logic [data_width-1:0] wdata_0,
    output logic [data_width-1:0] wdata_1,
    output logic [data_width-1:0] wdata_2,
    output logic [data_width-1:0] wdata_3,
    output logic                  busy,
    output logic                  stage_done
);

    localparam int CW  = clog2(PER_STAGE + 1);
    localparam int DLW = 1 + NUM_LANES * addr_width;
    localparam logic [CW-1:0] LAST_ISSUE = CW'(PER_STAGE - 1);
    localparam logic [CW-1:0] FULL_CNT   = CW'(PER_STAGE);

    wb_state_t     state;
    logic [CW-1:0] issue_cnt;
    logic [CW-1:0] wr_cnt;
    logic          accept;

    logic [NUM_LANES-1:0][addr_width-1:0] iaddr;
    logic [NUM_LANES-1:0][addr_width-1:0] daddr;
    logic [NUM_LANES-1:0][data_width-1:0] din;
    logic [NUM_LANES-1:0][addr_width-1:0] waddr_q;
    logic [NUM_LANES-1:0][data_width-1:0] wdata_q;
    logic                                 dvld;
    logic                                 wen_q;
    logic [DLW-1:0]                       dl_in;
    logic [DLW-1:0]                       dl_out;

    // Issues outside RUN never enter the pipeline, so they can never produce a write.
    assign accept = (state == RUN) && issue_valid;
    assign iaddr  = {issue_addr_3, issue_addr_2, issue_addr_1, issue_addr_0};
    assign din    = {d3, d2, d1, d0};
    assign dl_in  = {accept, iaddr};

    wb_delay_line #(
        .width(DLW),
        .depth(LAT)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .din (dl_in),
        .dout(dl_out)
    );

    assign {dvld, daddr} = dl_out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            issue_cnt <= '0;
            wr_cnt    <= '0;
        end else begin
            if (wen_q) wr_cnt <= wr_cnt + CW'(1);
            case (state)
                IDLE: begin
                    if (start) state <= RUN;
                end
                RUN: begin
                    if (issue_valid) begin
                        issue_cnt <= issue_cnt + CW'(1);
                        if (issue_cnt == LAST_ISSUE) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wr_cnt == FULL_CNT) state <= DONE;
                end
                DONE: begin
                    state     <= IDLE;
                    issue_cnt <= '0;
                    wr_cnt    <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address/data hold their last written value between groups.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wen_q <= dvld;
            if (dvld) begin
                waddr_q <= daddr;
                wdata_q <= din;
            end
        end
    end

    assign wen_0   = wen_q;
    assign wen_1   = wen_q;
    assign wen_2   = wen_q;
    assign wen_3   = wen_q;
    assign waddr_0 = waddr_q[0];
    assign waddr_1 = waddr_q[1];
    assign waddr_2 = waddr_q[2];
    assign waddr_3 = waddr_q[3];
    assign wdata_0 = wdata_q[0];
    assign wdata_1 = wdata_q[1];
    assign wdata_2 = wdata_q[2];
    assign wdata_3 = wdata_q[3];

    assign busy       = (state == RUN) || (state == DRAIN);
    assign stage_done = (state == DONE);

endmodule

// File: tb/tb_bf_wb_ctrl.sv
// Self-checking bench for bf_wb_ctrl: directed vector table, hand-written
// multi-cycle sequences and random traffic against a cycle-indexed reference model.
module tb_bf_wb_ctrl;

    localparam int DW  = 14;
    localparam int AW  = 6;
    localparam int LAT = 14;
    localparam int PS  = 64;
    localparam int INF = 1 << 30;

    logic clk, rst, start, issue_valid;
    logic [AW-1:0] issue_addr_0, issue_addr_1, issue_addr_2, issue_addr_3;
    logic [DW-1:0] d0, d1, d2, d3;
    logic          wen_0, wen_1, wen_2, wen_3, busy, stage_done;
    logic [AW-1:0] waddr_0, waddr_1, waddr_2, waddr_3;
    logic [DW-1:0] wdata_0, wdata_1, wdata_2, wdata_3;
    logic          u1_wen_0, u1_wen_1, u1_wen_2, u1_wen_3, u1_busy, u1_done;
    logic [AW-1:0] u1_waddr_0, u1_waddr_1, u1_waddr_2, u1_waddr_3;
    logic [DW-1:0] u1_wdata_0, u1_wdata_1, u1_wdata_2, u1_wdata_3;

    bf_wb_ctrl #(.data_width(DW), .addr_width(AW), .LAT(LAT), .PER_STAGE(PS)) u0 (
        .clk(clk), .rst(rst), .start(start), .issue_valid(issue_valid),
        .issue_addr_0(issue_addr_0), .issue_addr_1(issue_addr_1),
        .issue_addr_2(issue_addr_2), .issue_addr_3(issue_addr_3),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .wen_0(wen_0), .wen_1(wen_1), .wen_2(wen_2), .wen_3(wen_3),
        .waddr_0(waddr_0), .waddr_1(waddr_1), .waddr_2(waddr_2), .waddr_3(waddr_3),
        .wdata_0(wdata_0), .wdata_1(wdata_1), .wdata_2(wdata_2), .wdata_3(wdata_3),
        .busy(busy), .stage_done(stage_done));

    // Single-group stage instance, only checked during the vector table.
    bf_wb_ctrl #(.data_width(DW), .addr_width(AW), .LAT(LAT), .PER_STAGE(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .issue_valid(issue_valid),
        .issue_addr_0(issue_addr_0), .issue_addr_1(issue_addr_1),
        .issue_addr_2(issue_addr_2), .issue_addr_3(issue_addr_3),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .wen_0(u1_wen_0), .wen_1(u1_wen_1), .wen_2(u1_wen_2), .wen_3(u1_wen_3),
        .waddr_0(u1_waddr_0), .waddr_1(u1_waddr_1), .waddr_2(u1_waddr_2), .waddr_3(u1_waddr_3),
        .wdata_0(u1_wdata_0), .wdata_1(u1_wdata_1), .wdata_2(u1_wdata_2), .wdata_3(u1_wdata_3),
        .busy(u1_busy), .stage_done(u1_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: stage window [open_from, done_cyc], accepted issues by cycle,
    // and expected writes by the cycle they become visible.
    typedef struct packed {
        logic [3:0][AW-1:0] a;
        logic [3:0][DW-1:0] d;
    } wr_t;

    logic [3:0][AW-1:0] acc [int];
    wr_t expw [int];
    wr_t last;
    int  open_from, done_cyc, issued;

    task automatic m_reset();
        open_from = INF;
        done_cyc  = -1;
        issued    = 0;
        acc.delete();
        expw.delete();
        last = '0;
    endtask

    task automatic m_eval();
        bit idle, running;
        wr_t w;
        idle    = !(open_from <= cyc && cyc <= done_cyc);
        running = (open_from <= cyc) && (done_cyc == INF);
        if (acc.exists(cyc - LAT)) begin
            w.a = acc[cyc - LAT];
            w.d = {d3, d2, d1, d0};
            expw[cyc + 1] = w;
            acc.delete(cyc - LAT);
        end
        if (running && issue_valid) begin
            acc[cyc] = {issue_addr_3, issue_addr_2, issue_addr_1, issue_addr_0};
            issued++;
            if (issued == PS) done_cyc = cyc + LAT + 3;
        end
        if (idle && start) begin
            open_from = cyc + 1;
            done_cyc  = INF;
            issued    = 0;
        end
    endtask

    task automatic m_check();
        bit ew;
        ew = expw.exists(cyc);
        if (ew) begin
            last = expw[cyc];
            expw.delete(cyc);
        end
        chk("wen", {wen_3, wen_2, wen_1, wen_0}, ew ? 4'hf : 4'h0);
        chk("waddr", {waddr_3, waddr_2, waddr_1, waddr_0}, last.a);
        chk("wdata", {wdata_3, wdata_2, wdata_1, wdata_0}, last.d);
        chk("busy", busy, (open_from <= cyc) && (cyc < done_cyc));
        chk("stage_done", stage_done, cyc == done_cyc);
    endtask

    task automatic tick();
        if (rst) m_eval();
        @(posedge clk);
        cyc++;
        #1;
        m_check();
    endtask

    task automatic set_in(input logic st, input logic iv,
                          input logic [3:0][AW-1:0] a, input logic [3:0][DW-1:0] d);
        start = st; issue_valid = iv;
        issue_addr_0 = a[0]; issue_addr_1 = a[1]; issue_addr_2 = a[2]; issue_addr_3 = a[3];
        d0 = d[0]; d1 = d[1]; d2 = d[2]; d3 = d[3];
    endtask

    function automatic logic [3:0][AW-1:0] ra();
        logic [3:0][AW-1:0] r;
        for (int k = 0; k < 4; k++) r[k] = AW'($urandom);
        return r;
    endfunction

    function automatic logic [3:0][DW-1:0] rd();
        logic [3:0][DW-1:0] r;
        for (int k = 0; k < 4; k++) r[k] = DW'($urandom);
        return r;
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || stage_done) && n < 500) begin
            set_in(1'b0, 1'b0, ra(), rd());
            tick();
            n++;
        end
        chk("idle_timeout", busy || stage_done, 1'b0);
    endtask

    typedef struct {
        logic st, iv;
        logic [3:0][AW-1:0] a;
        logic [3:0][DW-1:0] d;
        logic ewen, ebusy, ebusy1, edone1;
        logic [3:0][AW-1:0] ewa;
        logic [3:0][DW-1:0] ewd;
    } vec_t;

    vec_t tbl [21];

    initial begin
        int nwen, first, lastw, bfirst, blast, ndone, dcyc, mism, nb;
        int q_iss[$];
        int q_wen[$];
        logic [3:0][AW-1:0] a;
        logic [3:0][DW-1:0] dd;
        bit iv, st, need;

        // Single-issue vectors, relative to the start cycle.
        for (int r = 0; r < 21; r++) begin
            tbl[r]        = '{default: '0};
            tbl[r].ebusy  = (r >= 1);
            tbl[r].ebusy1 = (r >= 1 && r <= 17);
            tbl[r].edone1 = (r == 18);
            tbl[r].ewen   = (r == 16);
            if (r >= 16) begin
                tbl[r].ewa = {6'd15, 6'd11, 6'd7, 6'd3};
                tbl[r].ewd = {14'd400, 14'd300, 14'd200, 14'd100};
            end
        end
        tbl[0].st  = 1'b1;
        tbl[1].iv  = 1'b1;
        tbl[1].a   = {6'd15, 6'd11, 6'd7, 6'd3};
        tbl[15].d  = {14'd400, 14'd300, 14'd200, 14'd100};

        // Reset with random activity, then release while start is high.
        m_reset();
        rst = 1'b0;
        set_in(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 6; i++) begin
            set_in(1'($urandom), 1'($urandom), ra(), rd());
            tick();
        end
        start = 1'b1;
        rst   = 1'b1;
        #2;
        set_in(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 20; i++) tick();

        // Directed single issue (both PER_STAGE=64 and PER_STAGE=1 instances).
        for (int r = 0; r < 21; r++) begin
            set_in(tbl[r].st, tbl[r].iv, tbl[r].a, tbl[r].d);
            chk("tbl_wen", {wen_3, wen_2, wen_1, wen_0}, {4{tbl[r].ewen}});
            chk("tbl_waddr", {waddr_3, waddr_2, waddr_1, waddr_0}, tbl[r].ewa);
            chk("tbl_wdata", {wdata_3, wdata_2, wdata_1, wdata_0}, tbl[r].ewd);
            chk("tbl_busy", busy, tbl[r].ebusy);
            chk("tbl_busy_ps1", u1_busy, tbl[r].ebusy1);
            chk("tbl_done_ps1", u1_done, tbl[r].edone1);
            tick();
        end
        for (int i = 0; i < 63; i++) begin
            set_in(1'b0, 1'b1, ra(), rd());
            tick();
        end
        wait_idle();

        // Full back-to-back stage.
        nwen = 0; first = -1; lastw = -1; bfirst = -1; blast = -1; ndone = 0; dcyc = -1;
        for (int r = 0; r <= 86; r++) begin
            for (int k = 0; k < 4; k++) begin
                a[k]  = (r >= 1 && r <= 64) ? AW'(r - 1) : '0;
                dd[k] = (r - 1 - LAT >= 0 && r - 1 - LAT < 64) ? DW'((r - 1 - LAT) * 4 + k) : '0;
            end
            set_in(r == 0, r >= 1 && r <= 64, a, dd);
            if (wen_0) begin nwen++; if (first < 0) first = r; lastw = r; end
            if (busy) begin if (bfirst < 0) bfirst = r; blast = r; end
            if (stage_done) begin ndone++; dcyc = r; end
            if (r == 53) begin
                chk("full_waddr2", waddr_2, 37);
                chk("full_wdata2", wdata_2, 37 * 4 + 2);
            end
            tick();
        end
        chk("full_nwen", nwen, 64);
        chk("full_first_wen", first, 16);
        chk("full_last_wen", lastw, 79);
        chk("full_busy_first", bfirst, 1);
        chk("full_busy_last", blast, 80);
        chk("full_ndone", ndone, 1);
        chk("full_done_cycle", dcyc, 81);

        // Gapped issues, stray starts, issues in IDLE and DRAIN.
        wait_idle();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, 1'b1, ra(), rd());
            tick();
        end
        nb = 0; ndone = 0;
        for (int r = 0; r < 170; r++) begin
            need = (r >= 1) && (r % 2 == 1) && (nb < 64);
            iv   = need || (nb >= 64 && r % 3 == 0);
            st   = (r == 0) || (r == 10) || (r == 51);
            if (need) begin q_iss.push_back(r); nb++; end
            set_in(st, iv, ra(), rd());
            if (wen_0) q_wen.push_back(r);
            if (stage_done) ndone++;
            tick();
        end
        mism = 0;
        for (int i = 0; i < q_wen.size() && i < q_iss.size(); i++)
            if (q_wen[i] != q_iss[i] + LAT + 1) mism++;
        chk("gap_nwen", q_wen.size(), 64);
        chk("gap_align", mism, 0);
        chk("gap_ndone", ndone, 1);

        // Reset during DRAIN with writes in flight.
        wait_idle();
        for (int r = 0; r <= 68; r++) begin
            set_in(r == 0, r >= 1 && r <= 64, ra(), rd());
            tick();
        end
        chk("pre_reset_busy", busy, 1'b1);
        #1;
        rst = 1'b0;
        m_reset();
        #1;
        m_check();
        tick();
        rst = 1'b1;
        nwen = 0; nb = 0;
        for (int i = 0; i < 40; i++) begin
            set_in(1'b0, 1'($urandom), ra(), rd());
            if (wen_0) nwen++;
            if (busy) nb++;
            tick();
        end
        chk("post_reset_nwen", nwen, 0);
        chk("post_reset_busy", nb, 0);
        ndone = 0;
        for (int r = 0; r < 400 && ndone == 0; r++) begin
            set_in(r == 0, 1'($urandom), ra(), rd());
            tick();
            if (stage_done) ndone++;
        end
        chk("post_reset_stage", ndone, 1);

        // Random traffic: three stages with random gaps and stray starts.
        ndone = 0;
        for (int r = 0; r < 4000 && ndone < 3; r++) begin
            set_in($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0, ra(), rd());
            tick();
            if (stage_done) ndone++;
        end
        chk("rand_stages", ndone, 3);
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
